// File: rtl/reg_serializer.sv
// reg_serializer: captures a parallel word on Start and shifts it out MSB first.
// One serial bit per cycle with Valid high. An optional even-parity bit follows the data.
// A one-cycle Done pulse ends each stream.
// The parity bit is enabled by defining the PARITY_EN macro.
// The default build (macro undefined) has no parity state and no parity logic.
// The reset is synchronous and active-high.
module reg_serializer #(
  parameter int unsigned DataWidth = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [DataWidth-1:0] DIn,
  output logic                 SOut,
  output logic                 Valid,
  output logic                 Busy,
  output logic                 Done
);

  // The bit counter doubles as the shadow index, so it only needs to reach DataWidth-1.
  localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
`ifdef PARITY_EN
  localparam logic [1:0] StPar   = 2'd3;
`endif

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] shadow_q, shadow_d;

  // Next-state logic. Start is only honoured in idle, so a stream in flight can never be
  // disturbed by new requests or by changes on DIn.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          shadow_d = DIn;
          cnt_d    = CntW'(DataWidth - 1);
          state_d  = StShift;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
`ifdef PARITY_EN
          state_d = StPar;
`else
          state_d = StDone;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef PARITY_EN
      StPar: begin
        state_d = StDone;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers. Reset wins over everything, including a simultaneous Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Outputs are decoded from the current state.
  // The shadow is never shifted; the counter selects the bit to send.
  always_comb begin
    SOut  = 1'b0;
    Valid = 1'b0;
    Busy  = (state_q != StIdle);
    Done  = (state_q == StDone);
    case (state_q)
      StShift: begin
        SOut  = shadow_q[cnt_q];
        Valid = 1'b1;
      end
`ifdef PARITY_EN
      StPar: begin
        SOut  = ^shadow_q;
        Valid = 1'b1;
      end
`endif
      default: begin
        SOut  = 1'b0;
        Valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_serializer.sv
// Directed testbench for reg_serializer.
// It instantiates one 16-bit DUT and one 8-bit DUT.
// Expected values are hand-derived per step.
module tb_reg_serializer;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [15:0] din;
  logic        sout, valid, busy, done;
  logic        start8;
  logic [7:0]  din8;
  logic        sout8, valid8, busy8, done8;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PARITY_EN
  localparam int ParExtra = 1;
`else
  localparam int ParExtra = 0;
`endif

  reg_serializer #(.DataWidth(16)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (start),
    .DIn   (din),
    .SOut  (sout),
    .Valid (valid),
    .Busy  (busy),
    .Done  (done)
  );

  reg_serializer #(.DataWidth(8)) u_dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (start8),
    .DIn   (din8),
    .SOut  (sout8),
    .Valid (valid8),
    .Busy  (busy8),
    .Done  (done8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // After this returns we are 1 time unit into the cycle that follows the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sout"}, {31'd0, sout}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // Start a 16-bit stream of w and check every cycle through the return to idle.
  // A non-zero inject_at drives Start=1 and DIn=FFFF during that cycle; both must be ignored.
  task automatic run_stream(input string tag, input logic [15:0] w, input int inject_at);
    logic par;
    par   = ^w;
    din   = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check({tag, "_sout"}, {31'd0, sout}, {31'd0, w[15-i]});
      check({tag, "_valid"}, {31'd0, valid}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_done_early"}, {31'd0, done}, 32'd0);
      if (i + 1 == inject_at) begin
        din   = 16'hFFFF;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
`ifdef PARITY_EN
    check({tag, "_par_sout"}, {31'd0, sout}, {31'd0, par});
    check({tag, "_par_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_par_done"}, {31'd0, done}, 32'd0);
    tick();
`endif
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_done_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_sout"}, {31'd0, sout}, 32'd0);
    tick();
    check_idle({tag, "_after"});
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  w8;
    int          period;
    int          ph;
    logic        exp_sout, exp_valid, exp_busy, exp_done;

    Reset  = 1'b1;
    start  = 1'b0;
    din    = '0;
    start8 = 1'b0;
    din8   = '0;
    tick();
    tick();
    check_idle("reset");
    check("reset8_busy", {31'd0, busy8}, 32'd0);
    Reset = 1'b0;
    tick();
    check_idle("idle");

    // Basic stream with the 00A0 pattern.
    run_stream("s00a0", 16'h00A0, 0);

    // Abort after 5 bits, then a fresh stream.
    din   = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort_sout", {31'd0, sout}, 32'd1);
      tick();
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_idle("abort");
    tick();
    check_idle("abort_next");
    run_stream("s0001", 16'h0001, 0);

    // Start and new DIn mid-stream must be ignored.
    run_stream("s1234", 16'h1234, 4);

    // Reset has priority over Start in the same cycle.
    Reset = 1'b1;
    start = 1'b1;
    din   = 16'hFFFF;
    tick();
    Reset = 1'b0;
    start = 1'b0;
    check_idle("rst_prio");

    // Start held high gives back-to-back streams, spaced 18 (19 with parity) cycles apart.
    w      = 16'h8001;
    din    = w;
    start  = 1'b1;
    period = 18 + ParExtra;
    tick();
    for (int c = 1; c <= 2 * period; c++) begin
      ph        = (c - 1) % period;
      exp_sout  = 1'b0;
      exp_valid = 1'b0;
      exp_busy  = 1'b1;
      exp_done  = 1'b0;
      if (ph < 16) begin
        exp_sout  = w[15-ph];
        exp_valid = 1'b1;
      end else if (ParExtra == 1 && ph == 16) begin
        exp_sout  = ^w;
        exp_valid = 1'b1;
      end else if (ph == period - 2) begin
        exp_done = 1'b1;
      end else begin
        exp_busy = 1'b0;
      end
      check("b2b_sout", {31'd0, sout}, {31'd0, exp_sout});
      check("b2b_valid", {31'd0, valid}, {31'd0, exp_valid});
      check("b2b_busy", {31'd0, busy}, {31'd0, exp_busy});
      check("b2b_done", {31'd0, done}, {31'd0, exp_done});
      if (c == 2 * period) start = 1'b0;
      tick();
    end
    check_idle("b2b_end");

    // 8-bit instance streaming A5.
    w8     = 8'hA5;
    din8   = w8;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    din8   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check("w8_sout", {31'd0, sout8}, {31'd0, w8[7-i]});
      check("w8_valid", {31'd0, valid8}, 32'd1);
      check("w8_done_early", {31'd0, done8}, 32'd0);
      tick();
    end
`ifdef PARITY_EN
    check("w8_par", {31'd0, sout8}, 32'd0);
    check("w8_par_valid", {31'd0, valid8}, 32'd1);
    tick();
`endif
    check("w8_done", {31'd0, done8}, 32'd1);
    check("w8_done_valid", {31'd0, valid8}, 32'd0);
    tick();
    check("w8_idle_busy", {31'd0, busy8}, 32'd0);
    check("w8_idle_done", {31'd0, done8}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 Parameter DataWidth, default 16: width of parallel word; legal range 2..32.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset; synchronous, active-high.
REQ-004 Start  input  1  request to capture DIn and begin serial readout; sampled only in IDLE.
REQ-005 DIn  input  DataWidth  parallel word read from the register's DOut.
REQ-006 SOut  output  1  serial data bit, MSB first.
REQ-007 Valid  output  1  high while SOut carries a data (or parity) bit.
REQ-008 Busy  output  1  high whenever state is not IDLE.
REQ-009 Done  output  1  one-cycle pulse after the last bit is sent.

Function
REQ-010 FSM states SHALL be IDLE, SHIFT, PAR, DONE; PAR exists only with PARITY_EN.
REQ-011 IDLE: Start=1 at edge N SHALL load DIn into an internal shadow register, load bit counter with DataWidth-1, and enter SHIFT.
REQ-012 SHIFT: cycles N+1 .. N+DataWidth SHALL drive SOut = shadow[DataWidth-1] down to shadow[0], one bit per cycle, Valid=1, Busy=1.
REQ-013 Counter SHALL decrement once per SHIFT cycle; at count 0, next state SHALL be PAR (if PARITY_EN) else DONE.
REQ-014 DONE: Done=1, Valid=0, Busy=1, SOut=0 for exactly one cycle, then IDLE.
REQ-015 IDLE: SOut=0, Valid=0, Busy=0, Done=0.
REQ-016 Start while Busy=1 SHALL be ignored; no queuing; shadow and stream unchanged.
REQ-017 DIn changes after capture edge SHALL NOT affect the stream in progress.
REQ-018 Start held continuously SHALL be re-accepted in the first IDLE cycle after DONE; minimum spacing between accepted Starts is DataWidth+2 cycles (DataWidth+3 with PARITY_EN).
REQ-019 Counter width SHALL be ceil(log2(DataWidth)) bits; no wrap-around beyond 0 SHALL occur.

Reset
REQ-020 Reset=1 at any edge, including mid-SHIFT, PAR, or DONE, SHALL force IDLE, shadow=0, counter=0, SOut=0, Valid=0, Busy=0, Done=0 on the following cycle; no Done pulse for an aborted stream.
REQ-021 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-022 Macro PARITY_EN: when defined, PAR state SHALL follow SHIFT for one cycle driving SOut = XOR of all captured bits (even parity), Valid=1, Busy=1; when undefined, SHIFT SHALL go directly to DONE and no parity logic SHALL be present.

Verification
REQ-023 DIn=16'h00A0, Start pulse at cycle 0 -> cycles 1..16 SOut = 0000_0000_1010_0000 with Valid=1, Done=1 at cycle 17 only, Busy=0 at cycle 18.
REQ-024 Reset=1 after 5 bits of DIn=16'hFFFF stream -> next cycle SOut=0, Valid=0, Busy=0; Done never asserts; new Start with 16'h0001 then streams fifteen 0s then 1.
REQ-025 Stream of 16'h1234 started; at cycle 4 DIn=16'hFFFF and Start=1 -> stream remains 0001_0010_0011_0100, single Done pulse.
REQ-026 Start held high with DIn=16'h8001 -> two back-to-back streams, second beginning exactly DataWidth+2 cycles after first Start.
REQ-027 PARITY_EN defined: DIn=16'h0001 -> parity bit 1 at cycle 17, Done at cycle 18; DIn=16'h00A0 -> parity bit 0.
REQ-028 DataWidth=8, DIn=8'hA5 -> SOut 1010_0101 over cycles 1..8, Done at cycle 9.
